alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 44 ++++
 rtl/alu_arbiter.sv | 149 ++++++++++++++
 tb/tb_alu_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Handshake bundle between two ALU requesters and the shared-ALU arbiter.
// master = requester side, slave = arbiter side.
interface alu_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [2:0]  req0_op;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic [2:0]  req1_op;
  logic        rsp0_valid;
  logic        rsp0_ready;
  logic [31:0] rsp0_result;
  logic        rsp0_zero;
  logic        rsp1_valid;
  logic        rsp1_ready;
  logic [31:0] rsp1_result;
  logic        rsp1_zero;
  logic        busy;
  logic        err_illegal;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_result, rsp0_zero,
    input  rsp1_valid, rsp1_result, rsp1_zero,
    input  busy, err_illegal
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_result, rsp0_zero,
    output rsp1_valid, rsp1_result, rsp1_zero,
    output busy, err_illegal
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter sharing one 32-bit ALU. One result is held at a time;
// a new operation may be accepted in the same cycle the held result is taken.

// Combinational 32-bit ALU; ops 110/111 are illegal and yield zero.
module alu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic [31:0] result,
  output logic        zero
);
  // Operation decode
  always_comb begin
    result = 32'h0000_0000;
    case (op)
      3'b000:  result = a + b;
      3'b001:  result = a - b;
      3'b010:  result = a & b;
      3'b011:  result = a | b;
      3'b100:  result = a ^ b;
      3'b101:  result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: result = 32'h0000_0000;
    endcase
  end

  assign zero = (result == 32'h0000_0000);
endmodule

module alu_arbiter #(
  parameter logic INIT_PRIO = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  state_t      state_r, state_nx_s;
  logic        owner_r;
  logic        prio_r;
  logic [31:0] a_r, b_r;
  logic [2:0]  op_r;
  logic        err_r;

  logic        rsp_hs_s;
  logic        accept_s;
  logic        contended_s;
  logic        gnt_s;
  logic        take_s;
  logic [31:0] sel_a_s, sel_b_s;
  logic [2:0]  sel_op_s;
  logic [31:0] alu_result_s;
  logic        alu_zero_s;

  // The single shared ALU always works on the held operands
  alu u_alu (
    .a      (a_r),
    .b      (b_r),
    .op     (op_r),
    .result (alu_result_s),
    .zero   (alu_zero_s)
  );

  // Accept window, grant selection and next-state logic
  always_comb begin
    rsp_hs_s    = 1'b0;
    gnt_s       = 1'b0;
    state_nx_s  = state_r;
    if (state_r == RESP) begin
      rsp_hs_s = owner_r ? bus.rsp1_ready : bus.rsp0_ready;
    end else begin
      rsp_hs_s = 1'b0;
    end
    accept_s    = !rst && ((state_r == IDLE) || rsp_hs_s);
    contended_s = bus.req0_valid && bus.req1_valid;
    if (contended_s) begin
      gnt_s = prio_r;
    end else if (bus.req1_valid) begin
      gnt_s = 1'b1;
    end else begin
      gnt_s = 1'b0;
    end
    take_s = accept_s && (bus.req0_valid || bus.req1_valid);
    case (state_r)
      IDLE:    state_nx_s = take_s ? RESP : IDLE;
      RESP:    state_nx_s = take_s ? RESP : (rsp_hs_s ? IDLE : RESP);
      default: state_nx_s = IDLE;
    endcase
  end

  // Operand mux for the granted requester
  always_comb begin
    sel_a_s  = bus.req0_a;
    sel_b_s  = bus.req0_b;
    sel_op_s = bus.req0_op;
    if (gnt_s) begin
      sel_a_s  = bus.req1_a;
      sel_b_s  = bus.req1_b;
      sel_op_s = bus.req1_op;
    end else begin
      sel_a_s  = bus.req0_a;
      sel_b_s  = bus.req0_b;
      sel_op_s = bus.req0_op;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Capture operands, owner, priority and sticky illegal-op flag on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_r <= 1'b0;
      prio_r  <= INIT_PRIO;
      a_r     <= 32'h0000_0000;
      b_r     <= 32'h0000_0000;
      op_r    <= 3'b000;
      err_r   <= 1'b0;
    end else if (take_s) begin
      owner_r <= gnt_s;
      a_r     <= sel_a_s;
      b_r     <= sel_b_s;
      op_r    <= sel_op_s;
      if (contended_s) begin
        prio_r <= ~gnt_s;
      end
      if (sel_op_s[2] && sel_op_s[1]) begin
        err_r <= 1'b1;
      end
    end
  end

  assign bus.req0_ready  = take_s && !gnt_s;
  assign bus.req1_ready  = take_s && gnt_s;
  assign bus.rsp0_valid  = (state_r == RESP) && !owner_r;
  assign bus.rsp1_valid  = (state_r == RESP) && owner_r;
  assign bus.rsp0_result = alu_result_s;
  assign bus.rsp1_result = alu_result_s;
  assign bus.rsp0_zero   = alu_zero_s;
  assign bus.rsp1_zero   = alu_zero_s;
  assign bus.busy        = (state_r == RESP);
  assign bus.err_illegal = err_r;
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: expected results are queued at request
// acceptance and compared when the matching response handshake occurs.
module tb_alu_arbiter;
  logic clk;
  logic rst;
  alu_arbiter_if bus ();

  alu_arbiter #(.INIT_PRIO(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        id;
    logic [31:0] res;
    logic        zero;
  } exp_t;

  exp_t sb[$];
  int   glog[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic        p0_hold, p1_hold;
  logic [31:0] p0_res, p1_res;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a ^ b;
      3'b101:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Per-cycle monitor: protocol invariants, hold stability, scoreboard pop/push
  always @(negedge clk) begin
    exp_t e;
    exp_t n;
    if (rst) begin
      p0_hold <= 1'b0;
      p1_hold <= 1'b0;
    end else begin
      check_eq("ready_excl", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
      check_eq("valid_excl", 32'(bus.rsp0_valid & bus.rsp1_valid), 32'd0);
      if (p0_hold) begin
        check_eq("hold0_valid", 32'(bus.rsp0_valid), 32'd1);
        check_eq("hold0_result", bus.rsp0_result, p0_res);
      end
      if (p1_hold) begin
        check_eq("hold1_valid", 32'(bus.rsp1_valid), 32'd1);
        check_eq("hold1_result", bus.rsp1_result, p1_res);
      end
      p0_hold <= bus.rsp0_valid && !bus.rsp0_ready;
      p1_hold <= bus.rsp1_valid && !bus.rsp1_ready;
      p0_res  <= bus.rsp0_result;
      p1_res  <= bus.rsp1_result;
      if ((bus.rsp0_valid && bus.rsp0_ready) || (bus.rsp1_valid && bus.rsp1_ready)) begin
        if (sb.size() == 0) begin
          check_eq("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check_eq("rsp_owner", 32'(bus.rsp1_valid), 32'(e.id));
          check_eq("rsp_result", e.id ? bus.rsp1_result : bus.rsp0_result, e.res);
          check_eq("rsp_zero", 32'(e.id ? bus.rsp1_zero : bus.rsp0_zero), 32'(e.zero));
        end
      end
      if (bus.req0_valid && bus.req0_ready) begin
        n.id   = 1'b0;
        n.res  = model_alu(bus.req0_op, bus.req0_a, bus.req0_b);
        n.zero = (n.res == 32'd0);
        sb.push_back(n);
        glog.push_back(0);
      end
      if (bus.req1_valid && bus.req1_ready) begin
        n.id   = 1'b1;
        n.res  = model_alu(bus.req1_op, bus.req1_a, bus.req1_b);
        n.zero = (n.res == 32'd0);
        sb.push_back(n);
        glog.push_back(1);
      end
    end
  end

  // Present one request and hold it until accepted, within a cycle budget
  task automatic send(input int id, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    bit got;
    int cnt;
    got = 1'b0;
    cnt = 0;
    if (id == 0) begin
      bus.req0_a = a; bus.req0_b = b; bus.req0_op = op; bus.req0_valid = 1'b1;
    end else begin
      bus.req1_a = a; bus.req1_b = b; bus.req1_op = op; bus.req1_valid = 1'b1;
    end
    while (!got && cnt < 20) begin
      @(negedge clk);
      got = (id == 0) ? bus.req0_ready : bus.req1_ready;
      cnt++;
    end
    if (!got) check_eq("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  // Stop a hung run with a failure line
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_a = 32'd0; bus.req0_b = 32'd0; bus.req0_op = 3'b000;
    bus.req1_valid = 1'b1; bus.req1_a = 32'd0; bus.req1_b = 32'd0; bus.req1_op = 3'b000;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
    check_eq("rst_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
    check_eq("rst_err", 32'(bus.err_illegal), 32'd0);
    check_eq("rst_req0_ready", 32'(bus.req0_ready), 32'd0);
    check_eq("rst_req1_ready", 32'(bus.req1_ready), 32'd0);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Single op: 5+3 on requester 0
    send(0, 32'd5, 32'd3, 3'b000);
    @(negedge clk);
    check_eq("single_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
    check_eq("single_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
    check_eq("single_result", bus.rsp0_result, 32'd8);
    check_eq("single_zero", 32'(bus.rsp0_zero), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Contention: both valid for four cycles, grants alternate back-to-back
    glog.delete();
    bus.req0_a = 32'd1; bus.req0_b = 32'd1; bus.req0_op = 3'b000;
    bus.req1_a = 32'd2; bus.req1_b = 32'd2; bus.req1_op = 3'b001;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("cont_ngrants", 32'(glog.size()), 32'd4);
    for (int i = 0; i < 4 && i < glog.size(); i++) begin
      check_eq($sformatf("cont_grant%0d", i), 32'(glog[i]), 32'(i % 2));
    end

    // Backpressure: SLT -5 < -3 held four cycles while req0 waits
    bus.rsp1_ready = 1'b0;
    send(1, -32'sd5, -32'sd3, 3'b101);
    bus.req0_a = 32'd10; bus.req0_b = 32'd20; bus.req0_op = 3'b000; bus.req0_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("bp_rsp1_valid", 32'(bus.rsp1_valid), 32'd1);
      check_eq("bp_result", bus.rsp1_result, 32'd1);
      check_eq("bp_req0_ready", 32'(bus.req0_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.rsp1_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_release_req0_ready", 32'(bus.req0_ready), 32'd1);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    @(negedge clk);
    check_eq("bp_next_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Illegal op is accepted, yields zero, and sets a sticky error
    send(0, 32'd7, 32'd9, 3'b111);
    @(negedge clk);
    check_eq("ill_result", bus.rsp0_result, 32'd0);
    check_eq("ill_zero", 32'(bus.rsp0_zero), 32'd1);
    check_eq("ill_err", 32'(bus.err_illegal), 32'd1);
    @(posedge clk); #1;
    send(1, 32'hffff_ffff, 32'd1, 3'b000);
    send(0, 32'hf0f0_f0f0, 32'h0ff0_0ff0, 3'b011);
    send(1, 32'hdead_beef, 32'h1234_5678, 3'b100);
    send(0, 32'h0000_00ff, 32'h0000_0f0f, 3'b010);
    @(posedge clk); #1;
    check_eq("ill_err_sticky", 32'(bus.err_illegal), 32'd1);

    // Reset while holding a result: contended grant makes prio point at 1
    bus.rsp0_ready = 1'b0;
    bus.req0_a = 32'd4; bus.req0_b = 32'd4; bus.req0_op = 3'b000;
    bus.req1_a = 32'd6; bus.req1_b = 32'd3; bus.req1_op = 3'b100;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    @(negedge clk);
    check_eq("rr_first_grant0", 32'(bus.req0_ready), 32'd1);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    @(negedge clk);
    check_eq("rr_hold_valid", 32'(bus.rsp0_valid), 32'd1);
    check_eq("rr_hold_busy", 32'(bus.busy), 32'd1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_eq("rr_rsp0_drop", 32'(bus.rsp0_valid), 32'd0);
    check_eq("rr_busy", 32'(bus.busy), 32'd0);
    check_eq("rr_err_clear", 32'(bus.err_illegal), 32'd0);
    sb.delete();
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    @(negedge clk);
    check_eq("rr_in_rst_ready0", 32'(bus.req0_ready), 32'd0);
    check_eq("rr_in_rst_ready1", 32'(bus.req1_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.rsp0_ready = 1'b1;
    @(negedge clk);
    check_eq("rr_init_prio_ready0", 32'(bus.req0_ready), 32'd1);
    check_eq("rr_init_prio_ready1", 32'(bus.req1_ready), 32'd0);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
